// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader
//   Pops bytes from a byte FIFO and parses framed configuration commands:
//   sync byte, opcode, address bytes, data bytes, XOR checksum. Frames that
//   pass the checksum are offered one at a time over a valid/ready handshake.
//   Frames that fail are dropped and counted.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   fifo_data      FIFO head byte, valid while fifo_nonempty is high
//   fifo_nonempty  FIFO holds at least one byte
//   fifo_next      pop request; the head byte is consumed at this clock edge
//   cmd_valid      a checked command is available
//   cmd_ready      downstream accepts the command
//   cmd_opcode     command opcode
//   cmd_addr       address field (first byte on the wire is the MSB)
//   cmd_data       data field (first byte on the wire is the MSB)
//   chk_err        one-cycle pulse when a frame fails its checksum
//   err_count      failed-frame count, saturating at 255
module fifo_frame_reader #(
   parameter logic [7:0]  SyncByte  = 8'hA5,
   parameter int unsigned AddrBytes = 1,
   parameter int unsigned DataBytes = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             fifo_data,
   input  logic                   fifo_nonempty,
   output logic                   fifo_next,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [7:0]             cmd_opcode,
   output logic [8*AddrBytes-1:0] cmd_addr,
   output logic [8*DataBytes-1:0] cmd_data,
   output logic                   chk_err,
   output logic [7:0]             err_count
);

   localparam int unsigned AddrW    = 8 * AddrBytes;
   localparam int unsigned DataW    = 8 * DataBytes;
   localparam int unsigned MaxBytes = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
   localparam int unsigned CntW     = $clog2(MaxBytes + 1);

   localparam logic [CntW-1:0] AddrLast = CntW'(AddrBytes - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(DataBytes - 1);

   localparam logic [2:0] StHunt   = 3'd0;
   localparam logic [2:0] StOpcode = 3'd1;
   localparam logic [2:0] StAddr   = 3'd2;
   localparam logic [2:0] StData   = 3'd3;
   localparam logic [2:0] StCheck  = 3'd4;
   localparam logic [2:0] StOutput = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       op_q, op_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [DataW-1:0] data_q, data_d;
   logic             chk_err_q, chk_err_d;
   logic [7:0]       err_q, err_d;

   // Reset gates the pop so no byte is lost while the parser is held.
   assign fifo_next = fifo_nonempty && (state_q != StOutput) && !reset;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      op_d      = op_q;
      addr_d    = addr_q;
      data_d    = data_q;
      chk_err_d = 1'b0;
      err_d     = err_q;
      case (state_q)
         StHunt: begin
            if (fifo_next && fifo_data == SyncByte) state_d = StOpcode;
         end
         StOpcode: begin
            if (fifo_next) begin
               op_d    = fifo_data;
               csum_d  = fifo_data;
               cnt_d   = AddrLast;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (fifo_next) begin
               // Shift-by-8 form works for a single-byte field as well.
               addr_d = (addr_q << 8) | AddrW'(fifo_data);
               csum_d = csum_q ^ fifo_data;
               if (cnt_q == '0) begin
                  cnt_d   = DataLast;
                  state_d = StData;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
         end
         StData: begin
            if (fifo_next) begin
               data_d = (data_q << 8) | DataW'(fifo_data);
               csum_d = csum_q ^ fifo_data;
               if (cnt_q == '0) state_d = StCheck;
               else             cnt_d   = cnt_q - CntW'(1);
            end
         end
         StCheck: begin
            if (fifo_next) begin
               if (fifo_data == csum_q) begin
                  state_d = StOutput;
               end else begin
                  chk_err_d = 1'b1;
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  state_d = StHunt;
               end
            end
         end
         StOutput: begin
            if (cmd_ready) state_d = StHunt;
         end
         default: state_d = StHunt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StHunt;
         cnt_q     <= '0;
         csum_q    <= '0;
         op_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         chk_err_q <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         chk_err_q <= chk_err_d;
         err_q     <= err_d;
      end
   end

   assign cmd_valid  = (state_q == StOutput);
   assign cmd_opcode = op_q;
   assign cmd_addr   = addr_q;
   assign cmd_data   = data_q;
   assign chk_err    = chk_err_q;
   assign err_count  = err_q;

endmodule
